// File: rtl/int_sqrt_pkg.sv
// int_sqrt shared types.
// FSM state encoding for the sequential root unit.
package int_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/int_sqrt_step.sv
// int_sqrt_step: one restoring root iteration.
// Trial-subtracts {Q,01} from {R,next two radicand bits}.
module int_sqrt_step #(
  parameter int K = 8
) (
  input  logic [K+1:0] r_i,
  input  logic [K-1:0] q_i,
  input  logic [1:0]   d_i,
  output logic [K+1:0] r_o,
  output logic [K-1:0] q_o
);

  logic [K+3:0] a;
  logic [K+3:0] b;
  logic [K+1:0] t;
  logic         ge;

  assign a  = {r_i, d_i};
  assign b  = {2'b00, q_i, 2'b01};
  assign ge = (a >= b);
  // a fits in K+2 bits whenever ge or restore is taken
  assign t  = a[K+1:0] - b[K+1:0];

  // Keep the trial difference when it is non-negative
  always_comb begin
    r_o = ge ? t : a[K+1:0];
  end

  if (K > 1) begin : g_wide
    assign q_o = {q_i[K-2:0], ge};
  end else begin : g_one
    assign q_o = ge;
  end

endmodule

// File: rtl/int_sqrt.sv
// int_sqrt: multi-cycle unsigned floor(sqrt(in)).
// One result bit per cycle, level done held until start drops.
module int_sqrt
  import int_sqrt_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in,
  output logic         done,
  output logic [N-1:0] out
);

  localparam int K  = (N + 1) / 2;
  localparam int CW = $clog2(K + 1);

  state_e          state_q, state_d;
  logic [K+1:0]    r_q, r_d, r_nx;
  logic [K-1:0]    q_q, q_d, q_nx;
  logic [2*K-1:0]  d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    out_q, out_d;
  logic            done_q, done_d;

  int_sqrt_step #(
    .K (K)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q[2*K-1:2*K-2]),
    .r_o (r_nx),
    .q_o (q_nx)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          d_d        = '0;
          d_d[N-1:0] = in;
          r_d        = '0;
          q_d        = '0;
          cnt_d      = CW'(K);
          state_d    = CALC;
        end
      end
      CALC: begin
        r_d   = r_nx;
        q_d   = q_nx;
        d_d   = d_q << 2;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          out_d        = '0;
          out_d[K-1:0] = q_nx;
          done_d       = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_int_sqrt.sv
// tb_int_sqrt: checks N=5 and N=16 instances
// against an arithmetic floor-sqrt model.
module tb_int_sqrt;

  logic        clk = 1'b0;
  logic        rst5, start5, done5;
  logic [4:0]  in5, out5;
  logic        rst16, start16, done16;
  logic [15:0] in16, out16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_sqrt #(.N(5)) u5 (
    .clk   (clk),
    .rst   (rst5),
    .start (start5),
    .in    (in5),
    .done  (done5),
    .out   (out5)
  );

  int_sqrt #(.N(16)) u16 (
    .clk   (clk),
    .rst   (rst16),
    .start (start16),
    .in    (in16),
    .done  (done16),
    .out   (out16)
  );

  function automatic longint ref_sqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic run5(input logic [4:0] v, input logic [4:0] late,
                      output logic [4:0] res, output int lat);
    @(negedge clk);
    in5 = v;
    start5 = 1'b1;
    @(posedge clk);
    #1;
    in5 = late;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done5) break;
    end
    res = out5;
    @(negedge clk);
    start5 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [15:0] v,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    in16 = v;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    in16 = $urandom;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done16) break;
    end
    res = out16;
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst5 = 1'b0; rst16 = 1'b0;
    start5 = 1'b0; start16 = 1'b0;
    in5 = '0; in16 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (done5 !== 1'b0) begin
      bad++;
      $display("FAIL reset_done5 got=%b exp=0", done5);
    end
    total++;
    if (out5 !== 5'd0) begin
      bad++;
      $display("FAIL reset_out5 got=%0d exp=0", out5);
    end
    total++;
    if (done16 !== 1'b0) begin
      bad++;
      $display("FAIL reset_done16 got=%b exp=0", done16);
    end
    total++;
    if (out16 !== 16'd0) begin
      bad++;
      $display("FAIL reset_out16 got=%0d exp=0", out16);
    end
    @(negedge clk);
    rst5 = 1'b1; rst16 = 1'b1;
  endtask

  task automatic test_exhaustive5();
    logic [4:0] res, exp;
    int lat;
    for (int v = 0; v < 32; v++) begin
      run5(5'(v), 5'(v), res, lat);
      exp = 5'(ref_sqrt(v));
      total++;
      if (res !== exp) begin
        bad++;
        $display("FAIL sqrt5 in=%0d got=%0d exp=%0d", v, res, exp);
      end
      total++;
      if (lat != 3) begin
        bad++;
        $display("FAIL lat5 in=%0d got=%0d exp=3", v, lat);
      end
    end
  endtask

  task automatic test_corners16();
    logic [15:0] vec [6];
    logic [15:0] res, exp, v;
    int lat;
    vec = '{16'd0, 16'd1, 16'd65535, 16'd65025, 16'd65024, 16'd40000};
    for (int i = 0; i < 26; i++) begin
      v = (i < 6) ? vec[i] : 16'($urandom);
      run16(v, res, lat);
      exp = 16'(ref_sqrt(longint'(v)));
      total++;
      if (res !== exp) begin
        bad++;
        $display("FAIL sqrt16 in=%0d got=%0d exp=%0d", v, res, exp);
      end
      total++;
      if (lat != 8) begin
        bad++;
        $display("FAIL lat16 in=%0d got=%0d exp=8", v, lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] res;
    int lat;
    @(negedge clk);
    in16 = 16'd40000;
    start16 = 1'b1;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done16) break;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in16 = 16'($urandom);
      total++;
      if (done16 !== 1'b1 || out16 !== 16'd200) begin
        bad++;
        $display("FAIL hold cyc=%0d done=%b out=%0d exp done=1 out=200",
                 i, done16, out16);
      end
    end
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (done16 !== 1'b0) begin
      bad++;
      $display("FAIL hold_drop done got=%b exp=0", done16);
    end
    run16(16'd9, res, lat);
    total++;
    if (res !== 16'd3) begin
      bad++;
      $display("FAIL hold_next got=%0d exp=3", res);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] res;
    int lat;
    run5(5'd25, 5'd25, res, lat);
    total++;
    if (res !== 5'd5) begin
      bad++;
      $display("FAIL pre_reset got=%0d exp=5", res);
    end
    @(negedge clk);
    in5 = 5'd31;
    start5 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst5 = 1'b0;
    #1;
    total++;
    if (done5 !== 1'b0 || out5 !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset done=%b out=%0d exp done=0 out=0",
               done5, out5);
    end
    start5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done5 !== 1'b0 || out5 !== 5'd0) begin
      bad++;
      $display("FAIL in_reset done=%b out=%0d exp done=0 out=0",
               done5, out5);
    end
    @(negedge clk);
    rst5 = 1'b1;
    run5(5'd16, 5'd16, res, lat);
    total++;
    if (res !== 5'd4 || lat != 3) begin
      bad++;
      $display("FAIL post_reset got=%0d lat=%0d exp=4 lat=3", res, lat);
    end
  endtask

  task automatic test_operand_stability();
    logic [4:0] res;
    int lat;
    run5(5'd25, 5'd7, res, lat);
    total++;
    if (res !== 5'd5) begin
      bad++;
      $display("FAIL stability got=%0d exp=5", res);
    end
  endtask

  task automatic test_start_through_reset();
    logic [4:0] res;
    int lat;
    @(negedge clk);
    rst5 = 1'b0;
    in5 = 5'd24;
    start5 = 1'b1;
    @(negedge clk);
    rst5 = 1'b1;
    @(posedge clk);
    #1;
    in5 = 5'd0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done5) break;
    end
    res = out5;
    total++;
    if (res !== 5'd4 || lat != 3) begin
      bad++;
      $display("FAIL start_thru_reset got=%0d lat=%0d exp=4 lat=3",
               res, lat);
    end
    @(negedge clk);
    start5 = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_exhaustive5();
    test_corners16();
    test_hold();
    test_mid_reset();
    test_operand_stability();
    test_start_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_sqrt.md
# int_sqrt

Multi-cycle, parameterised unsigned integer square root. Accepts an N-bit operand on a `start` request and returns floor(sqrt(in)) after a fixed number of cycles, flagged by a level `done`. It is a standalone arithmetic unit in the ALU/FPU module set. It uses a restoring digit-by-digit algorithm that resolves one result bit per cycle.

## Interface
- `N`, default 16: operand and result width in bits. Legal for N >= 2, odd or even.
- `clk`  input  1  rising-edge clock; the design's only clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request; sampled only in IDLE.
- `in`  input  N  unsigned radicand; sampled on the accepting edge only.
- `done`  output  1  result valid; level, registered.
- `out`  output  N  floor(sqrt(in)), zero-extended to N bits; registered.

## Operation
- K = ceil(N/2) iterations. Radicand is zero-extended to 2K bits.
- Result fits in K bits. `out[N-1:K]` is always 0.
- Internal registers:
  - remainder R, K+2 bits.
  - root Q, K bits.
  - operand shift register D, 2K bits.
  - iteration counter, clog2(K+1) bits.
- One iteration:
  - T = {R, D[2K-1:2K-2]} - {Q, 2'b01}.
  - If T >= 0: R = T, Q = {Q, 1}.
  - Else: R = {R, D[2K-1:2K-2]} and Q = {Q, 0}.
  - Then D <<= 2.
- FSM states:
  - IDLE: `done`=0.
    - If `start`=1: load D=in (zero-extended), R=0, Q=0, counter=K; go to CALC.
  - CALC: perform one iteration per cycle and decrement the counter.
    - On the iteration where counter reaches 0: register Q into `out` and go to DONE.
  - DONE: `done`=1 and `out` held stable.
    - Stay while `start`=1.
    - Go to IDLE when `start`=0.
- A new request needs `start` deasserted for at least one cycle after `done`, or a reset.
- `in` changes after the accepting edge have no effect on the current operation.
- Reset (`rst`=0), asynchronous, at any time including mid-CALC:
  - state=IDLE, `done`=0, `out`=0, all internal registers 0.
  - An in-flight operation is discarded with no partial result.
- `start` held high through reset release is accepted at the first rising edge after release.

## Timing
- Edge E0: `start`=1 sampled in IDLE, operand loaded.
- Edges E1..EK: the K iterations. Edge EK writes `out` and enters DONE.
- `done` rises after edge EK, i.e. K clock edges after acceptance.
  - Latency from acceptance: K cycles (N=5: 3; N=16: 8).
- `out` and `done` change in the same cycle. `out` is never valid while `done`=0.
- Throughput: one result per K+2 cycles minimum (K cycles, DONE, then IDLE).
- No combinational path from any input to any output.

## Structure
- Package `int_sqrt_pkg`: the FSM state enum (IDLE, CALC, DONE).
- Width helpers K and counter width are derived from N in the module as localparams, since they depend on the instance parameter.
- Sub-module `int_sqrt_step`, combinational: one restoring iteration.
  - Inputs: R, Q, next two radicand bits.
  - Outputs: next R, next Q.
  - The top level holds the FSM, registers and counter.

## Test plan
- N=5 exhaustive: in = 0..31, reset then `start`, wait `done`.
  - `out` = floor(sqrt(in)), e.g. 0->0, 1->1, 3->1, 4->2, 24->4, 25->5, 31->5.
  - `done` rises exactly 3 edges after acceptance.
- N=16 corners: 0->0, 1->1, 65535->255, 65025->255, 65024->254, 40000->200.
  - `done` rises 8 edges after acceptance.
- Hold/handshake:
  - Keep `start`=1 after `done`: `done` and `out` stay constant, with no restart.
  - Drop `start`: back to IDLE with `done`=0.
  - Next `start` with in=9 returns 3.
- Mid-operation reset: assert `rst`=0 asynchronously between clock edges during CALC.
  - `done`=0 and `out`=0 immediately.
  - After release, a new request with in=16 (N=5) returns 4.
- Operand stability: change `in` after the accepting edge (25 then 7).
  - Result is 5.
